// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, VC count and a VC-id helper.
// Field positions describe the mesh flit format; this block only reads VC_BIT.
package router_pkg;
  localparam int FLIT_W      = 64;
  localparam int VC_BIT      = 63;
  localparam int XDIR_BIT    = 62;
  localparam int YDIR_BIT    = 61;
  localparam int HOPX_MSB    = 55;
  localparam int HOPX_LSB    = 52;
  localparam int HOPY_MSB    = 51;
  localparam int HOPY_LSB    = 48;
  localparam int PAYLOAD_MSB = 47;
  localparam int PAYLOAD_LSB = 0;
  localparam int NUM_VC      = 2;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic flit_vc(input flit_t f);
    return f[VC_BIT];
  endfunction
endpackage

// File: rtl/vc_output_ctrl_if.sv
// Requester-side and link-side signals of one output-port controller.
// The controller binds the slave modport; the input ports / link model bind master.
interface vc_output_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 64
);
  // Handshake: req_si[i] is valid for flit req_di[i]; grant[i] is its same-cycle
  // ready, and the flit transfers on the clock edge where both are high. On the
  // link, out_so already includes out_ro, so out_so high means the flit is taken.
  logic [NUM_REQ-1:0]        req_si;
  logic [NUM_REQ*FLIT_W-1:0] req_di;
  logic [NUM_REQ-1:0]        grant;
  logic                      out_so;
  logic [FLIT_W-1:0]         out_do;
  logic                      out_ro;

  modport slave (
    input  req_si, req_di, out_ro,
    output grant, out_so, out_do
  );

  modport master (
    output req_si, req_di, out_ro,
    input  grant, out_so, out_do
  );
endinterface

// File: rtl/vc_output_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// Pointer storage lives in the parent so one picker serves one VC.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      winner
);

  logic          found;
  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx(ptr, k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        winner   = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_ctrl.sv
// Per-output-port controller: fills the VC equal to polarity from the requesters
// and drains the other VC to the link. Define VC_OCTRL_PERF_EN for flit/stall counters.
module vc_output_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = router_pkg::FLIT_W,
  parameter int VC_BIT  = router_pkg::VC_BIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               polarity,
  vc_output_ctrl_if.slave    bus
`ifdef VC_OCTRL_PERF_EN
  ,
  output logic [31:0]        flit_cnt,
  output logic [31:0]        stall_cnt
`endif
);
  import router_pkg::*;

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_VC-1:0]  buf_v;
  logic [FLIT_W-1:0]  buf_d   [NUM_VC];
  logic [IW-1:0]      rr_ptr  [NUM_VC];
  logic [NUM_REQ-1:0] elig    [NUM_VC];
  logic [NUM_REQ-1:0] arb_gnt [NUM_VC];
  logic [IW-1:0]      arb_win [NUM_VC];

  logic               fill_vc;
  logic               drain_vc;
  logic [IW-1:0]      win;
  logic [IW-1:0]      next_ptr;
  logic [FLIT_W-1:0]  win_flit;

  assign fill_vc  = polarity;
  assign drain_vc = ~polarity;

  // A full entry masks every request for its VC, so the holder simply retries.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        elig[v][i] = bus.req_si[i] && (bus.req_di[i*FLIT_W + VC_BIT] == v[0]) && !buf_v[v];
      end
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_arb
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
      .req    (elig[v]),
      .ptr    (rr_ptr[v]),
      .gnt    (arb_gnt[v]),
      .winner (arb_win[v])
    );
  end

  assign bus.grant = reset ? arb_gnt[fill_vc] : '0;
  assign win       = arb_win[fill_vc];
  assign next_ptr  = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);

  always_comb begin
    win_flit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) win_flit = bus.req_di[i*FLIT_W +: FLIT_W];
    end
  end

  assign bus.out_so = buf_v[drain_vc] & bus.out_ro & reset;
  assign bus.out_do = buf_d[drain_vc];

  // Fill and drain always touch different entries, so both updates can land together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_v <= '0;
      for (int v = 0; v < NUM_VC; v++) rr_ptr[v] <= '0;
    end else begin
      if (|bus.grant) begin
        buf_v[fill_vc]  <= 1'b1;
        buf_d[fill_vc]  <= win_flit;
        rr_ptr[fill_vc] <= next_ptr;
      end
      if (bus.out_so) buf_v[drain_vc] <= 1'b0;
    end
  end

`ifdef VC_OCTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      flit_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (bus.out_so && (flit_cnt != '1)) flit_cnt <= flit_cnt + 32'd1;
      if (buf_v[drain_vc] && !bus.out_ro && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_output_ctrl.sv
// Bench for vc_output_ctrl: directed scenarios plus randomized traffic against a
// queue/array reference model of the fill/drain rules.
module tb_vc_output_ctrl;
  import router_pkg::*;

  localparam int NR = 4;
  localparam int FW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic pol;
  always #5 clk = ~clk;

  vc_output_ctrl_if #(.NUM_REQ(NR), .FLIT_W(FW)) bus ();

`ifdef VC_OCTRL_PERF_EN
  logic [31:0] flit_cnt;
  logic [31:0] stall_cnt;
`endif

  vc_output_ctrl #(.NUM_REQ(NR), .FLIT_W(FW), .VC_BIT(VC_BIT)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .polarity (pol),
    .bus      (bus)
`ifdef VC_OCTRL_PERF_EN
    ,
    .flit_cnt (flit_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- reference model + scoreboard ----------------
  flit_t       m_buf [2];
  bit          m_v   [2];
  int          m_ptr [2];
  longint      m_flit;
  longint      m_stall;
  logic [NR-1:0] exp_grant;
  logic        exp_so;
  flit_t       exp_do;
  logic [FW-1:0] exp_q0[$];
  logic [FW-1:0] exp_q1[$];
  int total = 0;
  int bad   = 0;

  task automatic model_eval();
    int f, d, idx;
    f = int'(pol);
    d = f ^ 1;
    exp_grant = '0;
    if (rst_n === 1'b1 && !m_v[f]) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr[f] + k) % NR;
        if (exp_grant == '0 && bus.req_si[idx] && bus.req_di[idx*FW + VC_BIT] == f[0])
          exp_grant[idx] = 1'b1;
      end
    end
    exp_so = (rst_n === 1'b1) && m_v[d] && (bus.out_ro === 1'b1);
    exp_do = m_buf[d];
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    int f, d, w;
    bit stall;
    model_eval();
    f = int'(pol);
    d = f ^ 1;
    stall = (rst_n === 1'b1) && m_v[d] && (bus.out_ro !== 1'b1);
    w = -1;
    for (int k = 0; k < NR; k++) if (exp_grant[k]) w = k;
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_v[0] = 0; m_v[1] = 0; m_ptr[0] = 0; m_ptr[1] = 0;
      m_flit = 0; m_stall = 0;
    end else begin
      if (exp_so) begin m_v[d] = 0; m_flit++; end
      if (stall) m_stall++;
      if (w >= 0) begin
        m_buf[f] = bus.req_di[w*FW +: FW];
        m_v[f]   = 1;
        m_ptr[f] = (w + 1) % NR;
      end
    end
    #1 pol = ~pol;
  endtask

  // A granted requester drops its request, like a real input port moving on.
  task automatic tick_hold();
    logic [NR-1:0] g;
    tick();
    g = exp_grant;
    for (int i = 0; i < NR; i++) if (g[i]) bus.req_si[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input flit_t f);
    bus.req_si[i] = 1'b1;
    bus.req_di[i*FW +: FW] = f;
  endtask

  task automatic idle(input int n);
    bus.req_si = '0;
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic align(input logic p);
    if (pol !== p) tick();
  endtask

  task automatic pulse_reset();
    bus.req_si = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ro = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, {1'b1, 63'(i + 16)});
    for (int c = 0; c < 4; c++) begin
      #1 model_eval();
      total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant c=%0d: got %b want 0000", c, bus.grant); end
      total++; if (bus.out_so !== 1'b0) begin bad++; $display("FAIL reset_so c=%0d: got %b want 0", c, bus.out_so); end
      tick();
    end
    rst_n = 1'b1;
    #1 model_eval();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.grant); end
    total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL reset_first_model: got %b want %b", bus.grant, exp_grant); end
    tick();
    idle(3);
  endtask

  task automatic test_single_flit();
    flit_t fl;
    fl = 64'h8000_0000_0000_00AB;
    bus.out_ro = 1'b1;
    idle(1);
    align(1'b1);
    set_req(1, fl);
    #1 model_eval();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", bus.grant); end
    tick();
    bus.req_si = '0;
    #1 model_eval();
    total++; if (bus.out_so !== 1'b1) begin bad++; $display("FAIL single_so: got %b want 1", bus.out_so); end
    total++; if (bus.out_do !== fl) begin bad++; $display("FAIL single_do: got %h want %h", bus.out_do, fl); end
    tick();
    #1 model_eval();
    total++; if (bus.out_so !== 1'b0) begin bad++; $display("FAIL single_so_after: got %b want 0", bus.out_so); end
    tick();
  endtask

  task automatic test_polarity_mismatch();
    flit_t fl;
    fl = 64'h0000_0000_0000_0055;
    bus.out_ro = 1'b1;
    idle(1);
    align(1'b1);
    set_req(2, fl);
    #1 model_eval();
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL pol_mismatch_grant: got %b want 0000", bus.grant); end
    tick();
    #1 model_eval();
    total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL pol_match_grant: got %b want 0100", bus.grant); end
    tick();
    bus.req_si = '0;
    #1 model_eval();
    total++; if (bus.out_so !== 1'b1) begin bad++; $display("FAIL pol_so: got %b want 1", bus.out_so); end
    total++; if (bus.out_do !== fl) begin bad++; $display("FAIL pol_do: got %h want %h", bus.out_do, fl); end
    tick();
  endtask

  task automatic test_round_robin();
    int g = 0;
    int dn = 0;
    logic [NR-1:0] eg;
    pulse_reset();
    bus.out_ro = 1'b1;
    align(1'b1);
    for (int i = 0; i < NR; i++) set_req(i, {1'b1, 63'(i)});
    for (int c = 0; c < 10; c++) begin
      #1 model_eval();
      if (pol === 1'b1) begin
        eg = NR'(1 << (g % NR));
        total++; if (bus.grant !== eg) begin bad++; $display("FAIL rr_grant n=%0d: got %b want %b", g, bus.grant, eg); end
        g++;
      end else begin
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rr_idle_grant c=%0d: got %b want 0000", c, bus.grant); end
        total++; if (bus.out_so !== 1'b1 || bus.out_do[PAYLOAD_MSB:PAYLOAD_LSB] !== 48'(dn % NR)) begin
          bad++; $display("FAIL rr_drain n=%0d: got so=%b payload=%0d want so=1 payload=%0d", dn, bus.out_so, bus.out_do[PAYLOAD_MSB:PAYLOAD_LSB], dn % NR);
        end
        dn++;
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    flit_t fx, fy, fz;
    fx = 64'h8123_4567_89AB_CDEF;
    fy = 64'h8000_0000_0000_1111;
    fz = 64'h0000_0000_0000_2222;
    bus.out_ro = 1'b1;
    idle(3);
    align(1'b1);
    bus.out_ro = 1'b0;
    set_req(0, fx);
    #1 model_eval();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL bp_first_grant: got %b want 0001", bus.grant); end
    tick_hold();
    set_req(1, fy);
    set_req(2, fz);
    for (int c = 0; c < 6; c++) begin
      #1 model_eval();
      total++; if (bus.out_so !== 1'b0) begin bad++; $display("FAIL bp_so c=%0d: got %b want 0", c, bus.out_so); end
      total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL bp_grant_model c=%0d: got %b want %b", c, bus.grant, exp_grant); end
      if (pol === 1'b1) begin
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL bp_vc1_blocked c=%0d: got %b want 0000", c, bus.grant); end
      end
      if (c == 0) begin
        total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL bp_vc0_grant: got %b want 0100", bus.grant); end
      end
      tick_hold();
    end
    bus.out_ro = 1'b1;
    #1 model_eval();
    total++; if (bus.out_so !== 1'b1) begin bad++; $display("FAIL bp_release_so: got %b want 1", bus.out_so); end
    total++; if (bus.out_do !== fx) begin bad++; $display("FAIL bp_release_do: got %h want %h", bus.out_do, fx); end
    tick_hold();
    #1 model_eval();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL bp_retry_grant: got %b want 0010", bus.grant); end
    total++; if (bus.out_do !== fz || bus.out_so !== 1'b1) begin bad++; $display("FAIL bp_vc0_drain: got so=%b do=%h want so=1 do=%h", bus.out_so, bus.out_do, fz); end
    tick_hold();
    idle(3);
  endtask

  task automatic test_mid_reset();
    flit_t f0, f3;
    f0 = 64'h8000_0000_0000_0A00;
    f3 = 64'h8000_0000_0000_0A03;
    pulse_reset();
    bus.out_ro = 1'b0;
    align(1'b1);
    set_req(1, 64'h8000_0000_0000_0001);
    #1 model_eval();
    total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL mr_fill_vc1: got %b want 0010", bus.grant); end
    tick_hold();
    set_req(0, 64'h0000_0000_0000_0002);
    #1 model_eval();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL mr_fill_vc0: got %b want 0001", bus.grant); end
    tick_hold();
    bus.out_ro = 1'b1;
    rst_n = 1'b0;
    #1 model_eval();
    total++; if (bus.out_so !== 1'b0) begin bad++; $display("FAIL mr_reset_so: got %b want 0", bus.out_so); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL mr_reset_grant: got %b want 0000", bus.grant); end
    tick();
    rst_n = 1'b1;
    set_req(0, f0);
    set_req(3, f3);
    #1 model_eval();
    total++; if (bus.out_so !== 1'b0) begin bad++; $display("FAIL mr_after_so: got %b want 0", bus.out_so); end
    tick_hold();
    #1 model_eval();
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL mr_after_grant: got %b want 0001", bus.grant); end
    tick_hold();
    #1 model_eval();
    total++; if (bus.out_so !== 1'b1 || bus.out_do !== f0) begin bad++; $display("FAIL mr_after_drain: got so=%b do=%h want so=1 do=%h", bus.out_so, bus.out_do, f0); end
    tick_hold();
    #1 model_eval();
    total++; if (bus.grant !== 4'b1000) begin bad++; $display("FAIL mr_next_grant: got %b want 1000", bus.grant); end
    tick_hold();
    idle(3);
  endtask

  task automatic rand_cycle(input bit gen);
    flit_t fl;
    logic [FW-1:0] q;
    if (gen) begin
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_si[i] && $urandom_range(0, 9) < 3) begin
          fl = {$urandom, $urandom};
          fl[VC_BIT] = 1'($urandom_range(0, 1));
          set_req(i, fl);
        end
      end
      bus.out_ro = ($urandom_range(0, 3) != 0);
    end
    #1 model_eval();
    total++; if (bus.grant !== exp_grant) begin bad++; $display("FAIL rand_grant t=%0t: got %b want %b", $time, bus.grant, exp_grant); end
    total++; if (bus.out_so !== exp_so) begin bad++; $display("FAIL rand_so t=%0t: got %b want %b", $time, bus.out_so, exp_so); end
    for (int i = 0; i < NR; i++) begin
      if (exp_grant[i]) begin
        fl = bus.req_di[i*FW +: FW];
        if (flit_vc(fl)) exp_q1.push_back(fl); else exp_q0.push_back(fl);
      end
    end
    if (bus.out_so === 1'b1) begin
      if (pol === 1'b1) begin
        total++; if (exp_q0.size() == 0) begin bad++; $display("FAIL rand_vc0_underflow t=%0t: got do=%h want no send", $time, bus.out_do); end
        else begin q = exp_q0.pop_front(); if (bus.out_do !== q) begin bad++; $display("FAIL rand_vc0_data: got %h want %h", bus.out_do, q); end end
      end else begin
        total++; if (exp_q1.size() == 0) begin bad++; $display("FAIL rand_vc1_underflow t=%0t: got do=%h want no send", $time, bus.out_do); end
        else begin q = exp_q1.pop_front(); if (bus.out_do !== q) begin bad++; $display("FAIL rand_vc1_data: got %h want %h", bus.out_do, q); end end
      end
    end
    tick_hold();
  endtask

  task automatic test_random();
    exp_q0.delete();
    exp_q1.delete();
    bus.out_ro = 1'b1;
    idle(3);
    for (int c = 0; c < 400; c++) rand_cycle(1'b1);
    bus.req_si = '0;
    bus.out_ro = 1'b1;
    for (int c = 0; c < 4; c++) rand_cycle(1'b0);
    total++; if (exp_q0.size() + exp_q1.size() != 0) begin bad++; $display("FAIL rand_leftover: got %0d queued want 0", exp_q0.size() + exp_q1.size()); end
  endtask

`ifdef VC_OCTRL_PERF_EN
  task automatic test_perf();
    #1;
    total++; if (flit_cnt !== 32'(m_flit)) begin bad++; $display("FAIL perf_flit: got %0d want %0d", flit_cnt, m_flit); end
    total++; if (stall_cnt !== 32'(m_stall)) begin bad++; $display("FAIL perf_stall: got %0d want %0d", stall_cnt, m_stall); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    pol = 1'b1;
    bus.req_si = '0;
    bus.req_di = '0;
    bus.out_ro = 1'b0;
    m_v[0] = 0; m_v[1] = 0; m_ptr[0] = 0; m_ptr[1] = 0;
    m_buf[0] = '0; m_buf[1] = '0;
    m_flit = 0; m_stall = 0;
    test_reset();
    test_single_flit();
    test_polarity_mismatch();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
`ifdef VC_OCTRL_PERF_EN
    test_perf();
`endif
    test_random();
`ifdef VC_OCTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_output_ctrl.md
Name: vc_output_ctrl

Overview:
- Per-output-port controller for the 5-port mesh router.
- Arbitrates up to NUM_REQ input-port requesters onto one output link.
- Holds one flit per virtual channel (VC0, VC1) in single-entry output buffers.
- Sequences fill/drain by the router's even/odd polarity: the VC equal to polarity is filled internally; the other VC drains to the external link the same cycle.
- One instance per output direction (up, down, left, right, NIC).

Parameters:
- NUM_REQ, 4: number of requesting input ports (≥2).
- FLIT_W, 64: flit width in bits.
- VC_BIT, 63: flit bit index holding the VC id.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- polarity  input  1  router-wide cycle polarity; toggles every cycle
- req_si  input  NUM_REQ  per-requester flit-valid
- req_di  input  NUM_REQ*FLIT_W  per-requester flit; requester i occupies bits [i*FLIT_W +: FLIT_W]
- grant  output  NUM_REQ  one-hot acceptance; flit i is consumed at this clock edge
- out_so  output  1  output link send strobe
- out_do  output  FLIT_W  output link flit
- out_ro  input  1  downstream ready for the VC being drained this cycle

Behaviour:
- State:
  - buf_v[1:0], buf_d[1:0][FLIT_W-1:0]: one entry per VC.
  - rr_ptr[1:0][$clog2(NUM_REQ)-1:0]: round-robin pointer per VC.
- Reset (reset==0 at posedge): buf_v=0, rr_ptr=0. During reset grant=0 and out_so=0 combinationally. out_do is don't-care but must equal buf_d of the drained VC.
- Fill (VC f = polarity):
  - Requester i is eligible iff req_si[i] && req_di[i][VC_BIT]==f && !buf_v[f].
  - Winner is the first eligible index scanning rr_ptr[f], rr_ptr[f]+1, … mod NUM_REQ.
  - grant is combinational in the same cycle and one-hot or zero.
  - At posedge with a grant: buf_d[f]<=winner flit, buf_v[f]<=1, rr_ptr[f]<=(winner+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
- Drain (VC d = ~polarity):
  - out_so = buf_v[d] && out_ro && reset; out_do = buf_d[d].
  - At posedge with out_so: buf_v[d]<=0.
- Latency: a flit granted at cycle t (polarity p) appears on out_so at t+1 (polarity ~p) if out_ro=1. Otherwise it waits in multiples of 2 cycles.
- Fill and drain always address different VCs, so there is no same-entry read/write conflict and no bypass path.
- Full buffer: no grant for that VC; the requester holds req_si/req_di until granted.
- Requests whose VC ≠ polarity are ignored that cycle (no grant, no pointer change).
- Routing decisions (hop/dir fields) are made upstream; this block never inspects bits other than VC_BIT.

Optional Feature:
- VC_OCTRL_PERF_EN defined adds:
  - output flit_cnt[31:0]: count of out_so cycles, saturating at 32'hFFFF_FFFF.
  - output stall_cnt[31:0]: count of cycles with buf_v[~polarity] && !out_ro, saturating.
  - Both counters clear on reset.
- VC_OCTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg:
  - FLIT_W=64, VC_BIT=63, XDIR_BIT=62, YDIR_BIT=61.
  - HOPX field [55:52], HOPY field [51:48], PAYLOAD field [47:0].
  - Typedef flit_t.
  - Constant NUM_VC=2.
- Sub-module rr_arbiter:
  - Parameters NUM_REQ; inputs req, ptr; outputs one-hot gnt, winner index.
  - Purely combinational.
  - Instantiated once per VC, with pointer registers held in the parent.

Test Plan:
- Reset: reset=0 for 4 cycles with req_si=4'b1111 → grant=0, out_so=0. After release, the first grant goes to requester 0 (all pointers are 0).
- Single flit: requester 1 drives 64'h8000_0000_0000_00AB with polarity=1 → grant=4'b0010 that cycle. Next cycle (polarity=0, out_ro=1) → out_so=1, out_do=64'h8000_0000_0000_00AB. The following cycle → out_so=0.
- Polarity mismatch: requester 2 drives a VC0 flit 64'h0000_0000_0000_0055 while polarity=1 → grant=0. Next cycle (polarity=0) → grant=4'b0100. One cycle later it appears on out_do.
- Round-robin: all 4 requesters hold VC1 flits (payload = index) with out_ro=1 → grants on successive polarity=1 cycles are 0001, 0010, 0100, 1000, 0001. out_do payloads are 0, 1, 2, 3 in that order.
- Backpressure: buf VC1 full, out_ro=0 for 6 cycles → out_so=0, no VC1 grants, and VC0 traffic is still granted. Then out_ro=1 → the original VC1 flit is sent unchanged.
- Mid-operation reset: both buffers valid and rr_ptr[1]=2, then reset=0 for one cycle → buf_v=0, out_so=0. After release, a VC1 request from requesters 0 and 3 grants 0 first.
